// File: rtl/clk_pulse_monitor.sv
// Oversamples an async monitored clock on clk_in, measures high/low phases and checks them against expected lengths.
// mon_clk rise -> meas_valid is SYNC_STAGES+1 clk_in edges; no backpressure, reports are single-cycle pulses.
module clk_pulse_monitor #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 0
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  input  logic             err_clr,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_stuck
);

  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GC_W-1:0]  GC_FULL = GC_W'(LOCK_COUNT);
  localparam logic [GC_W-1:0]  GC_ONE  = GC_W'(1);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic               p_q;
  logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]   lo_cnt_q, lo_cnt_d;
  logic [CNT_W-1:0]   hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0]   high_len_q, high_len_d;
  logic [CNT_W-1:0]   low_len_q, low_len_d;
  logic [GC_W-1:0]    good_cnt_q, good_cnt_d;
  logic               meas_valid_q, meas_valid_d;
  logic               locked_q, locked_d;
  logic               err_period_q, err_period_d;
  logic               err_stuck_q, err_stuck_d;

  logic s, rise, fall, period_done, stuck, good;

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[CNT_W] ? -d : d;
  endfunction

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p_q;
  assign fall = ~s & p_q;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], mon_clk};
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    hi_cap_d     = hi_cap_q;
    high_len_d   = high_len_q;
    low_len_d    = low_len_q;
    good_cnt_d   = good_cnt_q;
    meas_valid_d = 1'b0;
    period_done  = 1'b0;
    stuck        = 1'b0;
    good         = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      hi_cnt_d   = '0;
      lo_cnt_d   = '0;
      good_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE:      state_d = WAIT_RISE;
        WAIT_RISE: if (rise) begin
          state_d  = MEAS_HIGH;
          hi_cnt_d = CNT_ONE;
        end
        MEAS_HIGH: if (fall) begin
          state_d  = MEAS_LOW;
          hi_cap_d = hi_cnt_q;
          lo_cnt_d = CNT_ONE;
        end else if (hi_cnt_q == CNT_MAX) stuck = 1'b1;
        else hi_cnt_d = hi_cnt_q + CNT_ONE;
        MEAS_LOW: if (rise) begin
          state_d     = MEAS_HIGH;
          hi_cnt_d    = CNT_ONE;
          period_done = 1'b1;
        end else if (lo_cnt_q == CNT_MAX) stuck = 1'b1;
        else lo_cnt_d = lo_cnt_q + CNT_ONE;
        default:   state_d = IDLE;
      endcase
    end
    // Compare against the values being reported, so locked moves together with meas_valid.
    if (period_done) begin
      high_len_d   = hi_cap_q;
      low_len_d    = lo_cnt_q;
      meas_valid_d = 1'b1;
      good = (abs_diff(hi_cap_q, exp_high) <= TOL_V) && (abs_diff(lo_cnt_q, exp_low) <= TOL_V);
      if (!good) good_cnt_d = '0;
      else if (good_cnt_q != GC_FULL) good_cnt_d = good_cnt_q + GC_ONE;
    end
    if (stuck) begin
      state_d    = WAIT_RISE;
      hi_cnt_d   = '0;
      lo_cnt_d   = '0;
      good_cnt_d = '0;
    end
    locked_d     = (good_cnt_d == GC_FULL);
    // A fresh error outranks a simultaneous clear.
    err_period_d = (period_done & ~good) | (err_period_q & ~err_clr);
    err_stuck_d  = stuck | (err_stuck_q & ~err_clr);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      p_q          <= 1'b0;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      hi_cap_q     <= '0;
      high_len_q   <= '0;
      low_len_q    <= '0;
      good_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_period_q <= 1'b0;
      err_stuck_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      p_q          <= s;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      hi_cap_q     <= hi_cap_d;
      high_len_q   <= high_len_d;
      low_len_q    <= low_len_d;
      good_cnt_q   <= good_cnt_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      err_period_q <= err_period_d;
      err_stuck_q  <= err_stuck_d;
    end
  end

  assign high_len   = high_len_q;
  assign low_len    = low_len_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err_period = err_period_q;
  assign err_stuck  = err_stuck_q;

endmodule

// File: tb/tb_clk_pulse_monitor.sv
// Bench for clk_pulse_monitor: two instances (TOL=0 and TOL=1) share stimulus; reports are
// checked against a table of periods and a transaction-level lock/error model.
module tb_clk_pulse_monitor;

  logic       clk_in = 1'b0;
  logic       reset, mon_clk, enable, err_clr;
  logic [7:0] exp_high, exp_low;
  logic [7:0] hl0, ll0, hl1, ll1;
  logic       mv0, lk0, ep0, es0, mv1, lk1, ep1, es1;

  always #5 clk_in = ~clk_in;

  clk_pulse_monitor #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(0)) dut0 (
    .clk_in(clk_in), .reset(reset), .mon_clk(mon_clk), .enable(enable),
    .exp_high(exp_high), .exp_low(exp_low), .err_clr(err_clr),
    .high_len(hl0), .low_len(ll0), .meas_valid(mv0), .locked(lk0),
    .err_period(ep0), .err_stuck(es0));

  clk_pulse_monitor #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(1)) dut1 (
    .clk_in(clk_in), .reset(reset), .mon_clk(mon_clk), .enable(enable),
    .exp_high(exp_high), .exp_low(exp_low), .err_clr(err_clr),
    .high_len(hl1), .low_len(ll1), .meas_valid(mv1), .locked(lk1),
    .err_period(ep1), .err_stuck(es1));

  typedef struct { int hi; int lo; int hl; int ll; int lk0; int ep0; int lk1; int ep1; } vec_t;
  typedef struct { int hl0; int ll0; int hl1; int ll1; int lk0; int ep0; int lk1; int ep1; int cyc; } rep_t;

  vec_t vec [19];
  vec_t exp_q [$];
  rep_t act_q [$];
  int   rise_q [$];
  rep_t cap;
  int   cyc = 0;
  int   mv1_cnt = 0;
  int   base_act, base_mv1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (!reset) begin
      if (mv0) begin
        cap.hl0 = hl0; cap.ll0 = ll0; cap.hl1 = hl1; cap.ll1 = ll1;
        cap.lk0 = lk0; cap.ep0 = ep0; cap.lk1 = lk1; cap.ep1 = ep1;
        cap.cyc = cyc;
        act_q.push_back(cap);
      end
      if (mv1) mv1_cnt++;
    end
  end

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic drive_level(input logic v, input int n);
    repeat (n) begin
      @(negedge clk_in);
      if (v && !mon_clk) rise_q.push_back(cyc);
      mon_clk = v;
    end
  endtask

  task automatic start_seg();
    rise_q.delete();
    exp_q.delete();
    base_act = act_q.size();
    base_mv1 = mv1_cnt;
  endtask

  task automatic run_rows(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      drive_level(1'b1, vec[i].hi);
      drive_level(1'b0, vec[i].lo);
      exp_q.push_back(vec[i]);
    end
  endtask

  // Closing rise reports the last period; then every report is compared in order.
  task automatic finish_seg(input string tag);
    rep_t r;
    drive_level(1'b1, 5);
    chk({tag, ".n_reports"}, act_q.size() - base_act, exp_q.size());
    chk({tag, ".n_reports_tol1"}, mv1_cnt - base_mv1, exp_q.size());
    for (int i = 0; i < exp_q.size() && base_act + i < act_q.size(); i++) begin
      r = act_q[base_act + i];
      chk($sformatf("%s[%0d].high_len", tag, i), r.hl0, exp_q[i].hl);
      chk($sformatf("%s[%0d].low_len", tag, i), r.ll0, exp_q[i].ll);
      chk($sformatf("%s[%0d].high_len_tol1", tag, i), r.hl1, exp_q[i].hl);
      chk($sformatf("%s[%0d].low_len_tol1", tag, i), r.ll1, exp_q[i].ll);
      chk($sformatf("%s[%0d].locked", tag, i), r.lk0, exp_q[i].lk0);
      chk($sformatf("%s[%0d].err_period", tag, i), r.ep0, exp_q[i].ep0);
      chk($sformatf("%s[%0d].locked_tol1", tag, i), r.lk1, exp_q[i].lk1);
      chk($sformatf("%s[%0d].err_period_tol1", tag, i), r.ep1, exp_q[i].ep1);
      if (i + 1 < rise_q.size())
        chk($sformatf("%s[%0d].latency", tag, i), r.cyc - rise_q[i + 1], 3);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".high_len"}, hl0, 0);   chk({tag, ".high_len_tol1"}, hl1, 0);
    chk({tag, ".low_len"}, ll0, 0);    chk({tag, ".low_len_tol1"}, ll1, 0);
    chk({tag, ".meas_valid"}, mv0, 0); chk({tag, ".meas_valid_tol1"}, mv1, 0);
    chk({tag, ".locked"}, lk0, 0);     chk({tag, ".locked_tol1"}, lk1, 0);
    chk({tag, ".err_period"}, ep0, 0); chk({tag, ".err_period_tol1"}, ep1, 0);
    chk({tag, ".err_stuck"}, es0, 0);  chk({tag, ".err_stuck_tol1"}, es1, 0);
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  initial begin
    int hi, lo, gc0, gc1, e0, e1, base;
    vec_t v;

    // {hi, lo, high_len, low_len, locked, err_period, locked_tol1, err_period_tol1}
    for (int i = 0; i <= 3; i++)   vec[i] = '{3, 5, 3, 5, (i == 3) ? 1 : 0, 0, (i == 3) ? 1 : 0, 0};
    vec[4] = '{4, 5, 4, 5, 0, 1, 1, 0};
    for (int i = 5; i <= 8; i++)   vec[i] = '{3, 5, 3, 5, (i == 8) ? 1 : 0, 1, 1, 0};
    for (int i = 9; i <= 12; i++)  vec[i] = '{3, 5, 3, 5, (i == 12) ? 1 : 0, 0, (i == 12) ? 1 : 0, 0};
    for (int i = 13; i <= 14; i++) vec[i] = '{3, 5, 3, 5, 0, 0, 0, 0};
    for (int i = 15; i <= 18; i++) vec[i] = '{4, 5, 4, 5, 0, 1, (i == 18) ? 1 : 0, 0};

    reset = 1'b1; mon_clk = 1'b0; enable = 1'b0; err_clr = 1'b0;
    exp_high = 8'd3; exp_low = 8'd5;
    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    reset = 1'b0;
    enable = 1'b1;

    // Lock, single bad period, re-lock
    start_seg();
    drive_level(1'b0, 3);
    run_rows(0, 8);
    finish_seg("lock");

    // err_clr alone, then err_clr coinciding with a bad compare
    drive_level(1'b1, 1); err_clr = 1'b1;
    drive_level(1'b1, 1); err_clr = 1'b0;
    chk("clr.err_period", ep0, 0);
    chk("clr.err_period_tol1", ep1, 0);
    drive_level(1'b0, 5);
    drive_level(1'b1, 3); err_clr = 1'b1;
    drive_level(1'b1, 1);
    chk("setwins.meas_valid", mv0, 1);
    chk("setwins.high_len", hl0, 7);
    chk("setwins.err_period", ep0, 1);
    chk("setwins.err_period_tol1", ep1, 1);
    chk("setwins.locked", lk0, 0);
    chk("setwins.locked_tol1", lk1, 0);
    drive_level(1'b1, 1); err_clr = 1'b0;
    chk("clr2.err_period", ep0, 0);
    chk("clr2.err_period_tol1", ep1, 0);

    // Stuck high, then recovery
    drive_level(1'b1, 300);
    chk("stuck.err_stuck", es0, 1);
    chk("stuck.err_stuck_tol1", es1, 1);
    chk("stuck.locked", lk0, 0);
    chk("stuck.locked_tol1", lk1, 0);
    chk("stuck.high_len_hold", hl0, 7);
    chk("stuck.high_len_hold_tol1", hl1, 7);
    start_seg();
    drive_level(1'b0, 5);
    run_rows(9, 12);
    finish_seg("stuck");

    // Enable dropped while measuring low phase
    drive_level(1'b0, 6);
    enable = 1'b0;
    drive_level(1'b0, 1);
    chk("dis.locked", lk0, 0);
    chk("dis.locked_tol1", lk1, 0);
    base = act_q.size();
    drive_level(1'b1, 4);
    drive_level(1'b0, 4);
    chk("dis.no_report", act_q.size() - base, 0);
    start_seg();
    enable = 1'b1;
    drive_level(1'b0, 3);
    run_rows(13, 14);
    finish_seg("reen");

    // Async reset in the middle of a high phase
    drive_level(1'b1, 2);
    #2 reset = 1'b1;
    #1 chk_all_zero("midreset");
    @(negedge clk_in) mon_clk = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    start_seg();
    drive_level(1'b0, 3);
    run_rows(15, 18);
    finish_seg("postreset");

    // Random periods against a lock/error model per tolerance
    @(negedge clk_in) reset = 1'b1;
    mon_clk = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    start_seg();
    drive_level(1'b0, 3);
    gc0 = 0; gc1 = 0; e0 = 0; e1 = 0;
    for (int n = 0; n < 40; n++) begin
      hi = ($urandom_range(0, 1) == 0) ? 3 : int'($urandom_range(2, 5));
      lo = ($urandom_range(0, 1) == 0) ? 5 : int'($urandom_range(4, 7));
      if (absd(hi, 3) <= 0 && absd(lo, 5) <= 0) gc0 = (gc0 < 4) ? gc0 + 1 : 4;
      else begin gc0 = 0; e0 = 1; end
      if (absd(hi, 3) <= 1 && absd(lo, 5) <= 1) gc1 = (gc1 < 4) ? gc1 + 1 : 4;
      else begin gc1 = 0; e1 = 1; end
      v = '{hi, lo, hi, lo, (gc0 == 4) ? 1 : 0, e0, (gc1 == 4) ? 1 : 0, e1};
      drive_level(1'b1, hi);
      drive_level(1'b0, lo);
      exp_q.push_back(v);
    end
    finish_seg("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
